// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern detector family.
//   - Default configuration constants (reset pattern, length, overlap mode).
//   - seq_clamp_len: maps a requested pattern length into 1..max_len.
package seq_pkg;

  localparam int          SEQ_MAX_LEN_DEF     = 8;
  localparam int          SEQ_CNT_W_DEF       = 8;
  localparam logic [7:0]  SEQ_RST_PATTERN_DEF = 8'b0000_1010;
  localparam int          SEQ_RST_LEN_DEF     = 4;
  localparam logic        SEQ_RST_OVERLAP_DEF = 1'b1;

  // A zero length would describe an empty pattern, so it is promoted to 1.
  // Anything beyond the history depth is cut back to the longest pattern
  // that can be held.
  function automatic int unsigned seq_clamp_len(input int unsigned len_in,
                                                input int unsigned max_len);
    int unsigned len_out;
    if (len_in == 32'd0) begin
      len_out = 32'd1;
    end else if (len_in > max_len) begin
      len_out = max_len;
    end else begin
      len_out = len_in;
    end
    return len_out;
  endfunction

endpackage

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector.
// Accepts one bit per valid cycle and compares the most recent len bits
// against a runtime-programmable pattern (bit [len-1] oldest, bit [0] newest).
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   cfg_load      capture cfg_pattern/cfg_len/cfg_overlap, clear history
//   cfg_pattern   pattern, LSB-aligned
//   cfg_len       pattern length (clamped to 1..MAX_LEN on capture)
//   cfg_overlap   1 = overlapping matches allowed, 0 = non-overlapping
//   in_valid, x   serial sample and its qualifier
//   cnt_clr       clear the match counter (wins over a same-cycle match)
//   match         combinational: the current sample completes the pattern
//   match_q       match delayed by one cycle
//   match_cnt     saturating number of matches
//   fill          valid history bits held, saturating at len-1
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int                 MAX_LEN     = SEQ_MAX_LEN_DEF,
  parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int                 CNT_W       = SEQ_CNT_W_DEF,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(SEQ_RST_PATTERN_DEF),
  parameter int                 RST_LEN     = SEQ_RST_LEN_DEF,
  parameter logic               RST_OVERLAP = SEQ_RST_OVERLAP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   fill
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  // The oldest bit of a MAX_LEN-deep history can never fall inside a window
  // (the window always includes the live sample x), so only MAX_LEN-1 bits
  // are stored.
  logic [MAX_LEN-2:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               match_q_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LEN_W-1:0]   len_m1_s;
  logic               accept_s;
  logic               match_s;

  // Window, per-length mask and match decision for the current sample.
  always_comb begin
    window_s = {hist_r, x};
    len_m1_s = len_r - LEN_W'(1);
    accept_s = in_valid & ~cfg_load & ~rst;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
    if (accept_s && (fill_r >= len_m1_s) &&
        (((window_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}})) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Active configuration: reset defaults or clamped capture on cfg_load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r <= RST_PATTERN;
      len_r <= LEN_W'(RST_LEN);
      ovl_r <= RST_OVERLAP;
    end else if (cfg_load) begin
      pat_r <= cfg_pattern;
      len_r <= LEN_W'(seq_clamp_len(32'(cfg_len), MAX_LEN));
      ovl_r <= cfg_overlap;
    end
  end

  // History shift register and fill count; a non-overlapping match restarts
  // the fill so the next match needs len fresh bits.
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (in_valid) begin
      hist_r <= window_s[MAX_LEN-2:0];
      if (match_s && !ovl_r) begin
        fill_r <= '0;
      end else if (fill_r < len_m1_s) begin
        fill_r <= fill_r + LEN_W'(1);
      end else begin
        fill_r <= fill_r;
      end
    end
  end

  // Delayed match and saturating counter; cnt_clr wins over a same-cycle match.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      match_q_r <= match_s;
      if (cnt_clr) begin
        cnt_r <= '0;
      end else if (match_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign match     = match_s;
  assign match_q   = match_q_r;
  assign match_cnt = cnt_r;
  assign fill      = fill_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (CNT_W=2 so that
// counter saturation is reachable with a short stimulus).
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               x;
  logic               cnt_clr;
  logic               match;
  logic               match_q;
  logic [CNT_W-1:0]   match_cnt;
  logic [LEN_W-1:0]   fill;

  int checks = 0;
  int errors = 0;

  seq_detect_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .x           (x),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_q     (match_q),
    .match_cnt   (match_cnt),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of input, check match mid-cycle and match_q after the edge.
  task automatic send(input logic v, input logic b, input logic exp_m);
    in_valid = v;
    x        = b;
    #1;
    chk_eq("match", 32'(match), 32'(exp_m));
    @(posedge clk);
    #1;
    chk_eq("match_q", 32'(match_q), 32'(exp_m));
    in_valid = 1'b0;
    x        = 1'b0;
  endtask

  // Send n bits MSB-first; exp holds the expected match per sample, same order.
  task automatic send_bits(input logic [7:0] bits, input int n, input logic [7:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      send(1'b1, bits[i], exp[i]);
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk_eq("cnt_after_clr", 32'(match_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] a5;
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    cfg_overlap = 1'b0; in_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_eq("rst_match",   32'(match),     32'd0);
    chk_eq("rst_match_q", 32'(match_q),   32'd0);
    chk_eq("rst_cnt",     32'(match_cnt), 32'd0);
    chk_eq("rst_fill",    32'(fill),      32'd0);
    rst = 1'b0;

    // 1: reset config 1010, overlap: matches on samples 4 and 6
    send_bits(8'b0010_1010, 6, 8'b0000_0101);
    chk_eq("t1_cnt", 32'(match_cnt), 32'd2);
    chk_eq("t1_fill", 32'(fill), 32'd3);
    clear_cnt();

    // 2: non-overlapping 1010: matches on samples 4 and 8
    load(8'h0A, 4'd4, 1'b0);
    send_bits(8'b1010_1010, 4, 8'b0000_0001);
    chk_eq("t2_fill_restart", 32'(fill), 32'd0);
    send_bits(8'b0000_1010, 4, 8'b0000_0001);
    chk_eq("t2_cnt", 32'(match_cnt), 32'd2);

    // 3: len 8, 0xA5 with gaps; cfg_load leaves the counter alone
    load(8'hA5, 4'd8, 1'b1);
    chk_eq("t3_cnt_kept", 32'(match_cnt), 32'd2);
    clear_cnt();
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send(1'b1, a5[i], (i == 0) ? 1'b1 : 1'b0);
      chk_eq("t3_fill", 32'(fill), (i == 0) ? 32'd7 : 32'(8 - i));
      send(1'b0, 1'b1, 1'b0);
      chk_eq("t3_fill_hold", 32'(fill), (i == 0) ? 32'd7 : 32'(8 - i));
    end
    chk_eq("t3_cnt", 32'(match_cnt), 32'd1);

    // 4: cfg_load with in_valid mid-pattern; clamp 0->1 and 15->8
    load(8'h0A, 4'd4, 1'b1);
    send_bits(8'b0000_0101, 3, 8'b0000_0000);
    chk_eq("t4_fill_pre", 32'(fill), 32'd3);
    cfg_pattern = 8'h01; cfg_len = 4'd0; cfg_overlap = 1'b1; cfg_load = 1'b1;
    send(1'b1, 1'b0, 1'b0);
    cfg_load = 1'b0;
    chk_eq("t4_fill_clear", 32'(fill), 32'd0);
    send_bits(8'b0000_0101, 3, 8'b0000_0101);
    load(8'hA5, 4'd15, 1'b1);
    send_bits(8'hA5, 8, 8'b0000_0001);

    // 5: len 1 continuous matches saturate at 3; cnt_clr beats a match
    load(8'h01, 4'd1, 1'b0);
    clear_cnt();
    send_bits(8'b0001_1111, 5, 8'b0001_1111);
    chk_eq("t5_sat", 32'(match_cnt), 32'd3);
    cnt_clr = 1'b1;
    send(1'b1, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    chk_eq("t5_clr_wins", 32'(match_cnt), 32'd0);

    // 6: reset mid-sequence restores 1010 and discards history
    load(8'h07, 4'd3, 1'b0);
    send_bits(8'b0000_0101, 3, 8'b0000_0000);
    rst = 1'b1;
    send(1'b1, 1'b0, 1'b0);
    chk_eq("t6_fill_rst", 32'(fill), 32'd0);
    chk_eq("t6_cnt_rst", 32'(match_cnt), 32'd0);
    rst = 1'b0;
    send(1'b1, 1'b0, 1'b0);
    send_bits(8'b0000_1010, 4, 8'b0000_0001);
    chk_eq("t6_cnt", 32'(match_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector for the mini-project FSM library, successor to the fixed 4-bit Mealy detectors. It accepts one bit per valid cycle, compares a sliding window against a runtime-programmable pattern of 1..MAX_LEN bits, and flags matches in overlapping or non-overlapping mode. It provides a combinational Mealy match, a registered Moore-style match, and a saturating match counter, so it can drive protocol front-ends, test harnesses, or LED/UART demo tops.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, >= 2
- LEN_W, $clog2(MAX_LEN)+1: width of the length field
- CNT_W, 8: match counter width
- RST_PATTERN, 8'b0000_1010: pattern loaded at reset, LSB-aligned
- RST_LEN, 4: length loaded at reset
- RST_OVERLAP, 1: overlap mode at reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_load  in  1  capture cfg_* and clear detection history
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first and bit [0] last
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- in_valid  in  1  x is a valid sample this cycle
- x  in  1  serial data bit
- cnt_clr  in  1  clear match_cnt
- match  out  1  combinational; current sample completes the pattern
- match_q  out  1  match registered, one cycle later
- match_cnt  out  CNT_W  saturating count of matches
- fill  out  LEN_W  valid history bits held, saturates at len-1

## Operation
- Internal registers:
  - pat, len, ovl: active configuration
  - hist[MAX_LEN-1:0]: shift register; on an accepted sample, hist <= {hist[MAX_LEN-2:0], x}
  - fill: history count
- Length clamping on load: cfg_len = 0 becomes 1; cfg_len > MAX_LEN becomes MAX_LEN. Clamping applies only at capture.
- Window: the low len bits of {hist, x}.
- Match condition: match = in_valid & !cfg_load & !rst & (fill >= len-1) & (window == pat[len-1:0]).
- Accepted sample (in_valid=1, cfg_load=0), updated in this order:
  - hist shifts in x.
  - If match and ovl=0: fill <= 0. The next match needs len fresh bits.
  - Otherwise: fill <= min(fill+1, len-1).
- Overlap mode: consecutive matches may share bits. Pattern 1010 on input 1010101 gives 2 matches.
- cfg_load=1:
  - pat, len, ovl are captured.
  - hist and fill are cleared.
  - A coincident in_valid sample is discarded and match is 0.
- match_cnt:
  - Increments by 1 on each match and saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle. The counter clears and that match is not counted.
  - cfg_load does not clear the counter.
- in_valid=0: hist, fill, and match_cnt hold; match=0.
- len=1: every valid sample equal to pat[0] matches. Overlap mode is irrelevant.

## Timing
- Reset values:
  - match=0, match_q=0, match_cnt=0, fill=0, hist=0
  - pat=RST_PATTERN, len=RST_LEN, ovl=RST_OVERLAP
- rst takes priority over cfg_load, cnt_clr, and in_valid.
- Reset mid-sequence discards partial history. The first match after reset needs len new samples.
- Latency:
  - match: 0 cycles, same cycle as the completing sample.
  - match_q and match_cnt: update on the next rising edge.
- No backpressure; a sample is accepted on every cycle with in_valid=1.
- Configuration changes take effect for the sample in the cycle after cfg_load.

## Structure
- Shared package seq_pkg holds:
  - default constants (RST_* values)
  - a length-clamp function, reused by future detectors
- Single module, no sub-modules. Estimated size is about 150 lines.
- Window compare: generate a per-length mask, then compare (window ^ pat) & mask == 0. No variable part-selects.

## Test plan
- Reset defaults, pattern 1010, overlap, input 1,0,1,0,1,0: match pulses on samples 4 and 6; match_q follows one cycle later; match_cnt=2.
- Load pattern 1010 with overlap=0, input 1,0,1,0,1,0,1,0: matches on samples 4 and 8 only; match_cnt=2.
- Load len=8, pattern 8'hA5, input 0xA5 MSB-first, with in_valid gaps between samples: exactly one match, on bit 8; fill holds during the gaps.
- Assert cfg_load together with in_valid mid-pattern: the sample is discarded; fill=0 next cycle; clamping maps cfg_len=0 to 1 and cfg_len=15 to 8.
- CNT_W=2 with a continuous len=1 pattern: match_cnt saturates at 3; cnt_clr coincident with a match leaves match_cnt=0.
- Assert rst after 3 bits of 1010, then send 0: no match; len fresh bits are needed before the next match.
